// File: rtl/sensor_membuf_rd.sv
// ============================================================================
//  Module   : sensor_membuf_rd
//  Purpose  : 4-page 64-bit line buffer. Each page is read back as a stream
//             of 16-bit pixels with a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_membuf_rd #(
    parameter int WADDR_WIDTH = 6
) (
    input  logic                   mclk,
    input  logic                   mrst_n,
    input  logic                   wpage_set,
    input  logic                   buf_we,
    input  logic [63:0]            buf_din,
    input  logic                   page_written,
    input  logic [WADDR_WIDTH+2:0] line_len,
    input  logic                   px_ready,
    output logic [15:0]            px_data,
    output logic                   px_valid,
    output logic                   last_in_line,
    output logic                   page_done,
    output logic                   pages_full,
    output logic                   overflow
);

    localparam int NUM_PAGES = 4;
    localparam int PIX_W     = WADDR_WIDTH + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    logic [63:0]            mem [0:(1 << PIX_W)-1];
    logic [63:0]            rdata;
    logic [PIX_W:0]         len_arr [0:NUM_PAGES-1];

    logic [1:0]             wpage;
    logic [1:0]             rpage;
    logic [WADDR_WIDTH-1:0] waddr;
    logic [2:0]             pend_cnt;
    logic [PIX_W-1:0]       pix_cnt;
    logic [PIX_W:0]         pix_nxt;
    logic [PIX_W:0]         len_cur;
    logic [1:0]             state;
    logic [1:0]             state_nxt;

    logic                   pw_ok;
    logic                   accept;
    logic                   is_last;
    logic                   rd_en;
    logic [PIX_W-1:0]       raddr;

    // A full page list swallows page_written; wpage_set masks everything.
    assign pw_ok   = page_written && !pages_full && !wpage_set;
    assign len_cur = len_arr[rpage];
    assign pix_nxt = {1'b0, pix_cnt} + (PIX_W+1)'(1);
    // A stored length of zero stands for a completely filled page.
    assign is_last = (len_cur == '0) ? (&pix_cnt) : (pix_nxt == len_cur);

    always_ff @(posedge mclk) begin
        if (buf_we && !wpage_set) begin
            mem[{wpage, waddr}] <= buf_din;
        end
        if (rd_en) begin
            rdata <= mem[raddr];
        end
        if (pw_ok) begin
            len_arr[wpage] <= line_len;
        end
    end

    // Word 0 is fetched in FETCH; later words are fetched as the 4th pixel
    // of the current word is accepted, keeping the stream gap-free.
    always_comb begin
        rd_en = 1'b0;
        raddr = {rpage, {WADDR_WIDTH{1'b0}}};
        if (state == ST_FETCH) begin
            rd_en = 1'b1;
        end else if (accept && (pix_cnt[1:0] == 2'b11) && !is_last) begin
            rd_en = 1'b1;
            raddr = {rpage, pix_cnt[PIX_W-1:2] + WADDR_WIDTH'(1)};
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            wpage    <= 2'd0;
            waddr    <= '0;
            rpage    <= 2'd0;
            pend_cnt <= 3'd0;
            pix_cnt  <= '0;
            overflow <= 1'b0;
        end else if (wpage_set) begin
            wpage    <= 2'd0;
            waddr    <= '0;
            rpage    <= 2'd0;
            pend_cnt <= 3'd0;
            pix_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (page_written && pages_full) begin
                overflow <= 1'b1;
            end
            if (pw_ok) begin
                wpage <= wpage + 2'd1;
                waddr <= '0;
            end else if (buf_we) begin
                waddr <= waddr + WADDR_WIDTH'(1);
            end
            case ({pw_ok, page_done})
                2'b10:   pend_cnt <= pend_cnt + 3'd1;
                2'b01:   pend_cnt <= pend_cnt - 3'd1;
                default: pend_cnt <= pend_cnt;
            endcase
            if (page_done) begin
                rpage   <= rpage + 2'd1;
                pix_cnt <= '0;
            end else if (accept) begin
                pix_cnt <= pix_nxt[PIX_W-1:0];
            end
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state <= ST_IDLE;
        end else if (wpage_set) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pend_cnt != 3'd0) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_EMIT;
            ST_EMIT:  if (page_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        px_valid     = (state == ST_EMIT);
        accept       = px_valid && px_ready;
        last_in_line = px_valid && is_last;
        page_done    = accept && is_last;
        pages_full   = (pend_cnt == 3'd4);
        px_data      = 16'd0;
        if (px_valid) begin
            case (pix_cnt[1:0])
                2'd0:    px_data = rdata[15:0];
                2'd1:    px_data = rdata[31:16];
                2'd2:    px_data = rdata[47:32];
                default: px_data = rdata[63:48];
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sensor_membuf_rd.sv
// ============================================================================
//  Module   : tb_sensor_membuf_rd
//  Purpose  : Directed bench for sensor_membuf_rd with a page/pixel-queue model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_membuf_rd;

    localparam int WW = 6;

    logic          mclk = 1'b0;
    logic          mrst_n = 1'b0;
    logic          wpage_set = 1'b0;
    logic          buf_we = 1'b0;
    logic [63:0]   buf_din = '0;
    logic          page_written = 1'b0;
    logic [WW+2:0] line_len = '0;
    logic          px_ready = 1'b0;
    logic [15:0]   px_data;
    logic          px_valid;
    logic          last_in_line;
    logic          page_done;
    logic          pages_full;
    logic          overflow;

    sensor_membuf_rd #(.WADDR_WIDTH(WW)) dut (
        .mclk         (mclk),
        .mrst_n       (mrst_n),
        .wpage_set    (wpage_set),
        .buf_we       (buf_we),
        .buf_din      (buf_din),
        .page_written (page_written),
        .line_len     (line_len),
        .px_ready     (px_ready),
        .px_data      (px_data),
        .px_valid     (px_valid),
        .last_in_line (last_in_line),
        .page_done    (page_done),
        .pages_full   (pages_full),
        .overflow     (overflow)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int pw_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a copy of every page plus a queue of the pixels still owed.
    logic [63:0] mmem [0:3][0:63];
    int          wpg_m = 0;
    int          wad_m = 0;
    int          pend_m = 0;
    bit          ovf_m = 0;
    logic [15:0] exp_d[$];
    bit          exp_l[$];
    bit          stall_prev = 0;
    logic [15:0] data_prev = '0;

    function automatic void model_clear();
        exp_d.delete();
        exp_l.delete();
        wpg_m = 0; wad_m = 0; pend_m = 0; ovf_m = 0; stall_prev = 0;
    endfunction

    function automatic void model_push(input int pg, input int len);
        int n;
        logic [63:0] w;
        n = (len == 0) ? 256 : len;
        for (int i = 0; i < n; i++) begin
            w = mmem[pg][i / 4];
            exp_d.push_back(w[16*(i % 4) +: 16]);
            exp_l.push_back(i == n - 1);
        end
    endfunction

    always @(negedge mclk) begin : cmp
        bit acc, lst, full_old;
        if (!mrst_n) begin
            model_clear();
        end else begin
            full_old = (pend_m == 4);
            chk("pages_full", pages_full, full_old);
            chk("overflow", overflow, ovf_m);
            if (stall_prev) begin
                chk("hold_valid", px_valid, 1'b1);
                chk("hold_data", px_data, data_prev);
            end
            acc = px_valid && px_ready;
            lst = 0;
            if (px_valid) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_px", px_valid, 1'b0);
                end else begin
                    chk("px_data", px_data, exp_d[0]);
                    chk("last_in_line", last_in_line, exp_l[0]);
                    lst = exp_l[0];
                end
            end else begin
                chk("last_idle", last_in_line, 1'b0);
            end
            chk("page_done", page_done, acc && lst);
            if (acc && exp_d.size() > 0) begin
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
                if (lst) pend_m--;
            end
            stall_prev = px_valid && !px_ready;
            data_prev  = px_data;
            if (wpage_set) begin
                model_clear();
            end else begin
                if (buf_we) mmem[wpg_m][wad_m] = buf_din;
                if (page_written && !full_old) begin
                    model_push(wpg_m, int'(line_len));
                    pend_m++;
                    wpg_m = (wpg_m + 1) % 4;
                    wad_m = 0;
                end else begin
                    if (page_written) ovf_m = 1;
                    if (buf_we) wad_m = (wad_m + 1) % 64;
                end
            end
        end
    end

    function automatic logic [63:0] wd(input int base, input int k);
        return {16'(base + k*4 + 3), 16'(base + k*4 + 2), 16'(base + k*4 + 1), 16'(base + k*4)};
    endfunction

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic write_page(input int base, input int n, input int len);
        for (int k = 0; k < n; k++) begin
            step();
            buf_we  = 1'b1;
            buf_din = wd(base, k);
        end
        step();
        buf_we       = 1'b0;
        page_written = 1'b1;
        line_len     = (WW+3)'(len);
        pw_cyc       = cyc;
        step();
        page_written = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        bit ok;
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge mclk);
            if (px_valid) begin ok = 1; break; end
        end
        if (!ok) chk(nm, px_valid, 1'b1);
    endtask

    task automatic wait_done(input string nm, input int maxc, output int span);
        bit ok;
        ok = 0;
        span = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge mclk);
            span++;
            if (page_done) begin ok = 1; break; end
        end
        if (!ok) chk(nm, page_done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int span, gap, ndone;
        bit ok;

        // Reset state
        #12;
        chk("rst_px_valid", px_valid, 1'b0);
        chk("rst_px_data", px_data, 16'd0);
        chk("rst_last", last_in_line, 1'b0);
        chk("rst_page_done", page_done, 1'b0);
        chk("rst_pages_full", pages_full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        step(); step();
        mrst_n = 1'b1;

        // Full 256-pixel page, latency 3, back-to-back pixels
        px_ready = 1'b1;
        write_page(0, 64, 0);
        wait_valid("t1_valid_timeout", 10);
        chk("t1_latency", cyc - pw_cyc, 3);
        chk("t1_first_px", px_data, 16'd0);
        wait_done("t1_done_timeout", 300, span);
        chk("t1_span", span + 1, 256);
        chk("t1_last_px", px_data, 16'd255);
        chk("t1_last_flag", last_in_line, 1'b1);

        // Short page: 5 pixels out of the first two words
        write_page(16'h100, 2, 5);
        wait_valid("t2_valid_timeout", 10);
        wait_done("t2_done_timeout", 20, span);
        chk("t2_last_px", px_data, 16'h104);
        chk("t2_span", span + 1, 5);
        step(); step(); step(); step();
        @(negedge mclk);
        chk("t2_idle", px_valid, 1'b0);

        // Two queued pages: two dead cycles between them
        px_ready = 1'b0;
        write_page(16'h200, 4, 13);
        write_page(16'h300, 3, 12);
        step();
        px_ready = 1'b1;
        wait_done("t3a_done_timeout", 40, span);
        chk("t3a_last_px", px_data, 16'h20C);
        gap = 0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge mclk);
            gap++;
            if (px_valid) begin ok = 1; break; end
        end
        chk("t3_gap", gap, 3);
        wait_done("t3b_done_timeout", 40, span);
        chk("t3b_last_px", px_data, 16'h30B);

        // Random backpressure
        write_page(16'h400, 16, 64);
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            px_ready = 1'($urandom_range(0, 1));
            @(negedge mclk);
            if (page_done) begin ok = 1; break; end
        end
        chk("t4_done", ok, 1'b1);
        step();
        px_ready = 1'b1;

        // Fill all four pages, then one page_written too many
        px_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            write_page(16'h500 + p*16, 1, 4);
            @(negedge mclk);
            chk("t5_full", pages_full, p == 3);
        end
        step();
        page_written = 1'b1;
        line_len     = 9'd4;
        step();
        page_written = 1'b0;
        @(negedge mclk);
        chk("t5_overflow", overflow, 1'b1);
        chk("t5_still_full", pages_full, 1'b1);
        step();
        px_ready = 1'b1;
        ndone = 0;
        for (int i = 0; i < 100 && ndone < 4; i++) begin
            @(negedge mclk);
            if (page_done) ndone++;
        end
        chk("t5_ndone", ndone, 4);
        step();
        @(negedge mclk);
        chk("t5_empty", pages_full, 1'b0);
        chk("t5_sticky", overflow, 1'b1);

        // page_written coinciding with page_done
        step();
        buf_we  = 1'b1;
        buf_din = wd(16'h600, 0);
        step();
        buf_we       = 1'b0;
        page_written = 1'b1;
        line_len     = 9'd4;
        step();
        page_written = 1'b0;
        buf_we       = 1'b1;
        buf_din      = wd(16'h610, 0);
        step();
        buf_we = 1'b0;
        step(); step(); step();
        step();
        page_written = 1'b1;
        line_len     = 9'd3;
        @(negedge mclk);
        chk("t6_same_cycle_done", page_done, 1'b1);
        step();
        page_written = 1'b0;
        wait_done("t6_done_timeout", 20, span);
        chk("t6_last_px", px_data, 16'h612);
        step(); step(); step(); step(); step(); step();
        @(negedge mclk);
        chk("t6_no_ghost", px_valid, 1'b0);

        // Synchronous clear mid-page
        write_page(16'h700, 2, 8);
        wait_valid("t7_valid_timeout", 10);
        step(); step();
        wpage_set = 1'b1;
        step();
        wpage_set = 1'b0;
        @(negedge mclk);
        chk("t7_cleared", px_valid, 1'b0);

        // Asynchronous reset mid-page
        write_page(16'h800, 8, 32);
        write_page(16'h900, 1, 2);
        wait_valid("t8_valid_timeout", 10);
        step(); step();
        chk("t8_pre_valid", px_valid, 1'b1);
        #1;
        mrst_n = 1'b0;
        #1;
        chk("t8_rst_valid", px_valid, 1'b0);
        chk("t8_rst_data", px_data, 16'd0);
        chk("t8_rst_last", last_in_line, 1'b0);
        chk("t8_rst_full", pages_full, 1'b0);
        step(); step();
        mrst_n = 1'b1;
        step(); step(); step(); step(); step();
        @(negedge mclk);
        chk("t8_no_pending", px_valid, 1'b0);
        write_page(16'hA00, 1, 4);
        wait_valid("t8b_valid_timeout", 10);
        chk("t8_new_first_px", px_data, 16'hA00);
        wait_done("t8b_done_timeout", 20, span);
        chk("t8_new_last_px", px_data, 16'hA03);

        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sensor_membuf_rd.md
SENSOR_MEMBUF_RD -- requirements
Module: sensor_membuf_rd

Interface
REQ-001: Parameter WADDR_WIDTH, default 6, log2 of 64-bit words per page; a page holds 4*2^WADDR_WIDTH 16-bit pixels.
REQ-002: Parameter NUM_PAGES is fixed at 4 (2-bit page index) and is not overridable.
REQ-003: mclk  input  1  sole clock; all logic on posedge mclk.
REQ-004: mrst_n  input  1  asynchronous, active-low reset.
REQ-005: wpage_set  input  1  synchronous clear of all pointers, counters and output state.
REQ-006: buf_we  input  1  write buf_din at the current write address, then increment that address.
REQ-007: buf_din  input  64  data word from the memory controller.
REQ-008: page_written  input  1  current write page complete; advance the write page and reset the word address to 0.
REQ-009: line_len  input  WADDR_WIDTH+3  pixels in the page, sampled with page_written; 0 means 4*2^WADDR_WIDTH.
REQ-010: px_ready  input  1  downstream accepts px_data this cycle.
REQ-011: px_data  output  16  pixel (or pixel pair) data.
REQ-012: px_valid  output  1  px_data valid.
REQ-013: last_in_line  output  1  qualifies px_valid; marks the last pixel of the page.
REQ-014: page_done  output  1  one-cycle pulse when the last pixel of a page is accepted.
REQ-015: pages_full  output  1  all 4 pages pending; the controller must not write.
REQ-016: overflow  output  1  sticky flag: page_written arrived while pages_full.

Function
REQ-017: Storage is a 4*2^WADDR_WIDTH x 64 RAM with a registered read (1-cycle latency); the write address is {wpage, waddr}.
REQ-018: line_len is held in a 4-entry array indexed by wpage and written on page_written.
REQ-019: pend_cnt range is 0..4:
- +1 on page_written when pend_cnt<4;
- -1 on page_done;
- unchanged when both occur in the same cycle;
- pages_full = (pend_cnt==4).
REQ-020: When pages_full is high, page_written does not change wpage, pend_cnt or the length array, and sets overflow.
REQ-021: The read FSM has three states:
- IDLE -> FETCH when pend_cnt>0;
- FETCH issues a RAM read of word 0 of rpage, then -> EMIT;
- EMIT -> IDLE after the last pixel is accepted.
REQ-022: Pixel order within a word is bits [15:0] first, then [31:16], [47:32], [63:48].
REQ-023: While px_valid && !px_ready, px_data, px_valid and last_in_line are held unchanged.
REQ-024: Prefetch: the next word is read while the 4th pixel of the current word is presented, so sustained throughput is 1 pixel/cycle within a page when px_ready is held high.
REQ-025: Latency: page_written in cycle N with the FSM in IDLE and pend_cnt 0 gives px_valid at cycle N+3.
REQ-026: There is exactly 2 dead cycles (IDLE, FETCH) between the last pixel of one page and the first pixel of the next.
REQ-027: last_in_line is asserted on pixel index line_len-1; pixels beyond line_len in the last word are discarded.
REQ-028: When the last pixel is accepted:
- page_done pulses in the same cycle;
- rpage increments modulo 4;
- the pixel counter returns to 0.
REQ-029: Write and read pointers wrap modulo 4 pages; waddr wraps modulo 2^WADDR_WIDTH and never crosses into the next page.
REQ-030: A same-address write and read in the same cycle returns the old data; this cannot occur in legal use because the controller respects pages_full.
REQ-031: wpage_set forces the same state as reset, except the RAM contents, and takes priority over every other input in that cycle.

Reset
REQ-032: On mrst_n low, the following clear asynchronously:
- px_valid, last_in_line, page_done, overflow = 0;
- px_data = 0;
- wpage, waddr, rpage, pend_cnt, pixel counter = 0;
- FSM = IDLE.
REQ-033: Reset mid-page drops the page; after release the block waits for a new page_written.

Verification
REQ-034: WADDR_WIDTH=6; write 64 words with buf_din = {k*4+3, k*4+2, k*4+1, k*4} (16-bit fields); page_written with line_len=0; px_ready=1 -> pixels 0..255 on consecutive cycles, last_in_line on 255, page_done once.
REQ-035: line_len=5 -> pixels 0..4, last_in_line on 4, pixels 5..7 never appear, page_done on acceptance of 4.
REQ-036: px_ready toggled by a random pattern -> px_data stable while stalled, no pixel lost or duplicated.
REQ-037: 5 page_written with no reading -> pages_full after the 4th, overflow=1 after the 5th, pend_cnt stays 4; read 4 pages -> pend_cnt=0, order page 0..3.
REQ-038: page_written and page_done in the same cycle -> pend_cnt unchanged.
REQ-039: Reset asserted while px_valid=1 mid-page -> outputs 0 asynchronously; pend_cnt=0 after release; a new page is emitted from pixel 0.
